serial_deserializer: RTL and testbench

//   Receive end of the 8-bit shift-register datapath. Assembles a serial bit

---
 rtl/serial_deserializer.sv | 93 +++++++++
 tb/tb_serial_deserializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles framed bit streams into WIDTH-bit
// words and presents them through a one-word valid/ready holding register.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic                       frame_start,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             in_shift;
    logic             capture;
    logic             restart;
    logic             complete;
    logic             consume;

    always_comb begin
        if (LSB_FIRST) sr_nxt = {bit_in, sr[WIDTH-1:1]};
        else           sr_nxt = {sr[WIDTH-2:0], bit_in};
    end

    assign in_shift = (state == SHIFT);
    assign capture  = bit_valid & (frame_start | in_shift);
    assign restart  = bit_valid & frame_start & in_shift;
    assign complete = bit_valid & ~frame_start & in_shift &
                      (bit_cnt == CNT_W'(WIDTH - 1));
    assign consume  = data_valid & data_ready;
    assign busy     = in_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= restart;
            if (bit_valid) sr <= sr_nxt;

            if (complete) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else if (capture & frame_start) begin
                state   <= SHIFT;
                bit_cnt <= CNT_W'(1);
            end else if (capture) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            // A consume on the same edge frees the slot for the new word
            if (complete & (~data_valid | data_ready)) begin
                data_out   <= sr_nxt;
                data_valid <= 1'b1;
            end else begin
                if (complete) overrun <= 1'b1;
                if (consume) data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized scoreboard bench for serial_deserializer (both bit orders).
module tb_serial_deserializer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       data_ready = 1'b0;

    logic [7:0] dl_data, dm_data;
    logic       dl_valid, dm_valid;
    logic       dl_busy, dm_busy;
    logic [3:0] dl_cnt, dm_cnt;
    logic       dl_ferr, dm_ferr;
    logic       dl_ovr, dm_ovr;

    serial_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .clr(clr),
        .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(dl_data), .data_valid(dl_valid), .data_ready(data_ready),
        .busy(dl_busy), .bit_cnt(dl_cnt), .frame_err(dl_ferr), .overrun(dl_ovr)
    );

    serial_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .clr(clr),
        .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(dm_data), .data_valid(dm_valid), .data_ready(data_ready),
        .busy(dm_busy), .bit_cnt(dm_cnt), .frame_err(dm_ferr), .overrun(dm_ovr)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    bit   fb[$];
    logic [7:0] ql[$];
    logic [7:0] qm[$];
    bit   m_full = 0;
    bit   m_ovr = 0;
    bit   m_ferr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fb.delete();
        ql.delete();
        qm.delete();
        m_full = 0;
        m_ovr = 0;
        m_ferr = 0;
    endtask

    // Frame-level model: a list of received bits turned into words arithmetically
    task automatic model_step();
        bit cons;
        bit ld;
        int wl;
        int wm;
        cons = m_full && data_ready;
        ld = 0;
        m_ferr = 0;
        if (clr) begin
            model_reset();
            return;
        end
        if (bit_valid) begin
            if (frame_start) begin
                if (fb.size() > 0) m_ferr = 1;
                fb.delete();
                fb.push_back(bit_in);
            end else if (fb.size() > 0) begin
                fb.push_back(bit_in);
                if (fb.size() == W) begin
                    wl = 0;
                    wm = 0;
                    for (int i = 0; i < W; i++) begin
                        wl += int'(fb[i]) * (1 << i);
                        wm += int'(fb[i]) * (1 << (W - 1 - i));
                    end
                    fb.delete();
                    if (!m_full || cons) begin
                        ql.push_back(8'(wl));
                        qm.push_back(8'(wm));
                        ld = 1;
                    end else begin
                        m_ovr = 1;
                    end
                end
            end
        end
        if (ld) m_full = 1;
        else if (cons) m_full = 0;
    endtask

    task automatic step(input bit bv, input bit b, input bit fs,
                        input bit rdy, input bit c);
        bit_valid = bv;
        bit_in = b;
        frame_start = fs;
        data_ready = rdy;
        clr = c;
        model_step();
        @(posedge clk);
        #1;
        chk("valid_l", dl_valid, m_full);
        chk("valid_m", dm_valid, m_full);
        chk("overrun", dl_ovr, m_ovr);
        chk("busy", dl_busy, fb.size() > 0);
        chk("bit_cnt", dl_cnt, fb.size());
        chk("frame_err", dl_ferr, m_ferr);
    endtask

    task automatic send_word(input logic [7:0] v, input bit rdy,
                             input bit rdy_last);
        for (int i = 0; i < W; i++)
            step(1, v[i], i == 0, (i == W - 1) ? rdy_last : rdy, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_data"}, dl_data, 0);
        chk({nm, "_valid"}, dl_valid, 0);
        chk({nm, "_busy"}, dl_busy, 0);
        chk({nm, "_cnt"}, dl_cnt, 0);
        chk({nm, "_ferr"}, dl_ferr, 0);
        chk({nm, "_ovr"}, dl_ovr, 0);
    endtask

    // Monitor: a transfer happens on the coming edge when valid & ready
    always @(negedge clk) begin
        if (!rst && !clr && dl_valid && data_ready) begin
            if (ql.size() == 0 || qm.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h want none", dl_data);
            end else begin
                chk("word_lsb", dl_data, ql.pop_front());
                chk("word_msb", dm_data, qm.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A5 in both bit orders, valid for exactly one cycle
        send_word(8'hA5, 1, 1);
        chk("t1_data", dl_data, 8'hA5);
        chk("t2_data", dm_data, 8'hA5);
        step(0, 0, 0, 1, 0);
        chk("t1_valid_fall", dl_valid, 0);

        // Back-pressure: second word dropped, first held
        send_word(8'h3C, 0, 0);
        send_word(8'hC3, 0, 0);
        chk("t3_hold", dl_data, 8'h3C);
        chk("t3_ovr", dl_ovr, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t3_empty", dl_valid, 0);

        // Back-to-back, then completion coinciding with a consume
        send_word(8'h11, 1, 1);
        send_word(8'h22, 1, 1);
        send_word(8'h33, 0, 0);
        send_word(8'h44, 0, 1);
        chk("t4_nogap", dl_valid, 1);
        chk("t4_data", dl_data, 8'h44);
        step(0, 0, 0, 1, 0);

        // Restart mid-frame
        step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        send_word(8'h5A, 1, 1);
        chk("t5_data", dl_data, 8'h5A);
        step(0, 0, 0, 1, 0);

        // Async reset mid-frame
        for (int i = 0; i < 5; i++) step(1, 1, i == 0, 1, 0);
        chk("t6_cnt5", dl_cnt, 5);
        rst = 1'b1;
        #1;
        chk_zero("t6_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Synchronous clear while holding a word, then a stray bit
        send_word(8'h7E, 0, 0);
        chk("t6_held", dl_valid, 1);
        step(0, 0, 0, 0, 1);
        chk_zero("t6_clr");
        step(1, 1, 0, 1, 0);
        chk("t6_stray", dl_cnt, 0);

        for (int n = 0; n < 600; n++) begin
            bit fs;
            fs = (fb.size() == 0) ? ($urandom_range(4, 0) != 0)
                                  : ($urandom_range(40, 0) == 0);
            step($urandom_range(3, 0) != 0, 1'($urandom), fs,
                 $urandom_range(2, 0) != 0, $urandom_range(150, 0) == 0);
        end

        repeat (3) step(0, 0, 0, 1, 0);
        chk("drain", ql.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
